// File: rtl/commit_rob.sv
// commit_rob: in-order commit queue. Allocates on issue, captures FU writebacks by tid and retires
// the oldest entries on in-order acks. Define COMMIT_ROB_WB_BYPASS_EN for 0-cycle writeback-to-commit.
module commit_rob #(
    parameter int NR_ENTRIES      = 8,
    parameter int NR_COMMIT_PORTS = 2,
    parameter int NR_WB_PORTS     = 4,
    parameter int XLEN            = 64,
    parameter int VLEN            = 39,
    localparam int TIDW           = $clog2(NR_ENTRIES)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  flush_i,
    input  logic                                  issue_valid_i,
    output logic                                  issue_ready_o,
    input  logic [VLEN-1:0]                       issue_pc_i,
    input  logic [4:0]                            issue_rd_i,
    output logic [TIDW-1:0]                       issue_tid_o,
    input  logic [NR_WB_PORTS-1:0]                wb_valid_i,
    input  logic [NR_WB_PORTS-1:0][TIDW-1:0]      wb_tid_i,
    input  logic [NR_WB_PORTS-1:0][XLEN-1:0]      wb_result_i,
    input  logic [NR_WB_PORTS-1:0]                wb_ex_i,
    output logic [NR_COMMIT_PORTS-1:0]            commit_valid_o,
    output logic [NR_COMMIT_PORTS-1:0][TIDW-1:0]  commit_tid_o,
    output logic [NR_COMMIT_PORTS-1:0][VLEN-1:0]  commit_pc_o,
    output logic [NR_COMMIT_PORTS-1:0][4:0]       commit_rd_o,
    output logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]  commit_result_o,
    output logic [NR_COMMIT_PORTS-1:0]            commit_ex_o,
    input  logic [NR_COMMIT_PORTS-1:0]            commit_ack_i
);

    typedef struct packed {
        logic [VLEN-1:0] pc;
        logic [4:0]      rd;
        logic [XLEN-1:0] result;
        logic            ex;
    } entry_t;

    localparam logic [TIDW:0] FULL = (TIDW+1)'(NR_ENTRIES);

    entry_t [NR_ENTRIES-1:0] mem_q;
    logic   [NR_ENTRIES-1:0] alloc_q, done_q;
    logic   [TIDW-1:0]       head_q, tail_q;
    logic   [TIDW:0]         cnt_q;

    logic                            issue_fire;
    logic [NR_ENTRIES-1:0]           wb_hit, wb_acc, wb_ex_sel, ret_ent;
    logic [NR_ENTRIES-1:0][XLEN-1:0] wb_res_sel;
    logic [TIDW:0]                   n_ret;

    assign issue_ready_o = (cnt_q != FULL);
    assign issue_tid_o   = tail_q;
    assign issue_fire    = issue_valid_i & issue_ready_o;

    // Per-entry writeback select; descending scan so the lowest port wins a tid collision.
    always_comb begin
        wb_hit     = '0;
        wb_res_sel = '0;
        wb_ex_sel  = '0;
        for (int e = 0; e < NR_ENTRIES; e++) begin
            for (int k = NR_WB_PORTS-1; k >= 0; k--) begin
                if (wb_valid_i[k] && (wb_tid_i[k] == TIDW'(e))) begin
                    wb_hit[e]     = 1'b1;
                    wb_res_sel[e] = wb_result_i[k];
                    wb_ex_sel[e]  = wb_ex_i[k];
                end
            end
        end
    end

    assign wb_acc = wb_hit & alloc_q & ~done_q;

    // Commit window and in-order retire chain: a gap in acks/valids kills everything above it.
    always_comb begin
        logic [TIDW-1:0] e;
        logic            in_order;
        e               = '0;
        in_order        = 1'b1;
        commit_valid_o  = '0;
        commit_tid_o    = '0;
        commit_pc_o     = '0;
        commit_rd_o     = '0;
        commit_result_o = '0;
        commit_ex_o     = '0;
        ret_ent         = '0;
        n_ret           = '0;
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            e                  = head_q + TIDW'(i);
            commit_tid_o[i]    = e;
            commit_valid_o[i]  = alloc_q[e] & done_q[e];
            commit_pc_o[i]     = mem_q[e].pc;
            commit_rd_o[i]     = mem_q[e].rd;
            commit_result_o[i] = mem_q[e].result;
            commit_ex_o[i]     = mem_q[e].ex;
`ifdef COMMIT_ROB_WB_BYPASS_EN
            if (wb_acc[e]) begin
                commit_valid_o[i]  = 1'b1;
                commit_result_o[i] = wb_res_sel[e];
                commit_ex_o[i]     = wb_ex_sel[e];
            end
`endif
            in_order = in_order & commit_ack_i[i] & commit_valid_o[i];
            if (in_order) begin
                ret_ent[e] = 1'b1;
                n_ret      = n_ret + (TIDW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q   <= '0;
            alloc_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
        end else if (flush_i) begin
            alloc_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
        end else begin
            for (int e = 0; e < NR_ENTRIES; e++) begin
                if (wb_acc[e]) begin
                    done_q[e]       <= 1'b1;
                    mem_q[e].result <= wb_res_sel[e];
                    mem_q[e].ex     <= wb_ex_sel[e];
                end
                if (ret_ent[e]) alloc_q[e] <= 1'b0;
            end
            // The tail slot is never allocated, so it cannot collide with a retiring or written entry.
            if (issue_fire) begin
                alloc_q[tail_q]  <= 1'b1;
                done_q[tail_q]   <= 1'b0;
                mem_q[tail_q].pc <= issue_pc_i;
                mem_q[tail_q].rd <= issue_rd_i;
                tail_q           <= tail_q + TIDW'(1);
            end
            head_q <= head_q + n_ret[TIDW-1:0];
            cnt_q  <= cnt_q + (TIDW+1)'(issue_fire) - n_ret;
        end
    end

    // Writebacks must target an allocated, not-yet-written entry.
    always_ff @(posedge clk_i) begin
        if (rst_ni && !flush_i) begin
            for (int k = 0; k < NR_WB_PORTS; k++) begin
                if (wb_valid_i[k]) assert (alloc_q[wb_tid_i[k]] && !done_q[wb_tid_i[k]]);
            end
        end
    end

endmodule

// File: tb/tb_commit_rob.sv
// tb_commit_rob: directed scoreboard bench for commit_rob; issue order is queued, writeback results
// are recorded by tid, and each retiring commit port is popped and compared against the model.
module tb_commit_rob;
    localparam int NE = 8, NC = 2, NW = 4, XLEN = 64, VLEN = 39, TIDW = 3;

    logic                          clk_i = 1'b0;
    logic                          rst_ni = 1'b1;
    logic                          flush_i = 1'b0;
    logic                          issue_valid_i = 1'b0;
    logic                          issue_ready_o;
    logic [VLEN-1:0]               issue_pc_i;
    logic [4:0]                    issue_rd_i;
    logic [TIDW-1:0]               issue_tid_o;
    logic [NW-1:0]                 wb_valid_i;
    logic [NW-1:0][TIDW-1:0]       wb_tid_i;
    logic [NW-1:0][XLEN-1:0]       wb_result_i;
    logic [NW-1:0]                 wb_ex_i;
    logic [NC-1:0]                 commit_valid_o;
    logic [NC-1:0][TIDW-1:0]       commit_tid_o;
    logic [NC-1:0][VLEN-1:0]       commit_pc_o;
    logic [NC-1:0][4:0]            commit_rd_o;
    logic [NC-1:0][XLEN-1:0]       commit_result_o;
    logic [NC-1:0]                 commit_ex_o;
    logic [NC-1:0]                 commit_ack_i;

    commit_rob #(
        .NR_ENTRIES(NE), .NR_COMMIT_PORTS(NC), .NR_WB_PORTS(NW), .XLEN(XLEN), .VLEN(VLEN)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_pc_i(issue_pc_i), .issue_rd_i(issue_rd_i), .issue_tid_o(issue_tid_o),
        .wb_valid_i(wb_valid_i), .wb_tid_i(wb_tid_i), .wb_result_i(wb_result_i), .wb_ex_i(wb_ex_i),
        .commit_valid_o(commit_valid_o), .commit_tid_o(commit_tid_o), .commit_pc_o(commit_pc_o),
        .commit_rd_o(commit_rd_o), .commit_result_o(commit_result_o), .commit_ex_o(commit_ex_o),
        .commit_ack_i(commit_ack_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int              tid;
        logic [VLEN-1:0] pc;
        logic [4:0]      rd;
    } exp_t;

    exp_t            exp_q[$];
    logic [XLEN-1:0] m_res [NE];
    logic            m_ex  [NE];
    logic [NE-1:0]   wr_now;
    int              m_tail = 0;
    int              n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
        wr_now = '0;
    endtask

    task automatic do_issue(input logic [VLEN-1:0] pc, input logic [4:0] rd);
        issue_valid_i = 1'b1;
        issue_pc_i    = pc;
        issue_rd_i    = rd;
        #1;
        chk("issue_ready", 64'(issue_ready_o), 64'd1);
        chk("issue_tid", 64'(issue_tid_o), 64'(m_tail));
        exp_q.push_back('{tid: m_tail, pc: pc, rd: rd});
        m_tail = (m_tail + 1) % NE;
        step();
        issue_valid_i = 1'b0;
    endtask

    // Ports driven in ascending order, so the first write of a tid in a cycle is the winner.
    task automatic set_wb(input int k, input int tid, input logic [XLEN-1:0] res, input logic ex);
        wb_valid_i[k]  = 1'b1;
        wb_tid_i[k]    = TIDW'(tid);
        wb_result_i[k] = res;
        wb_ex_i[k]     = ex;
        if (!wr_now[tid]) begin
            m_res[tid] = res;
            m_ex[tid]  = ex;
        end
        wr_now[tid] = 1'b1;
    endtask

    task automatic clr_wb();
        wb_valid_i = '0;
    endtask

    task automatic do_commit(input int n);
        exp_t e;
        #1;
        for (int i = 0; i < n; i++) begin
            chk("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() == 0) break;
            e = exp_q.pop_front();
            chk($sformatf("commit_valid[%0d]", i), 64'(commit_valid_o[i]), 64'd1);
            chk($sformatf("commit_tid[%0d]", i), 64'(commit_tid_o[i]), 64'(e.tid));
            chk($sformatf("commit_pc[%0d]", i), 64'(commit_pc_o[i]), 64'(e.pc));
            chk($sformatf("commit_rd[%0d]", i), 64'(commit_rd_o[i]), 64'(e.rd));
            chk($sformatf("commit_result[%0d]", i), commit_result_o[i], m_res[e.tid]);
            chk($sformatf("commit_ex[%0d]", i), 64'(commit_ex_o[i]), 64'(m_ex[e.tid]));
            commit_ack_i[i] = 1'b1;
        end
        step();
        commit_ack_i = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        wb_valid_i = '0; wb_tid_i = '0; wb_result_i = '0; wb_ex_i = '0;
        commit_ack_i = '0; issue_pc_i = '0; issue_rd_i = '0; wr_now = '0;
        for (int e = 0; e < NE; e++) begin
            m_res[e] = '0;
            m_ex[e]  = 1'b0;
        end
        #2 rst_ni = 1'b0;
        #3;
        chk("rst_ready", 64'(issue_ready_o), 64'd1);
        chk("rst_tid", 64'(issue_tid_o), 64'd0);
        chk("rst_valid", 64'(commit_valid_o), 64'd0);
        chk("rst_pc0", 64'(commit_pc_o[0]), 64'd0);
        chk("rst_result0", commit_result_o[0], 64'd0);
        chk("rst_result1", commit_result_o[1], 64'd0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // fill the queue, nothing written back
        for (int j = 0; j < NE; j++) do_issue(VLEN'(64'h100 + 4*j), 5'(j + 1));
        #1;
        chk("full_ready", 64'(issue_ready_o), 64'd0);
        chk("full_valid", 64'(commit_valid_o), 64'd0);

        // out-of-order writebacks; port 1 beats port 3 on tid 0
        set_wb(0, 1, 64'hA, 1'b0);
        step(); clr_wb(); #1;
        chk("wb1_valid", 64'(commit_valid_o), 64'h2);
        set_wb(1, 0, 64'hB, 1'b0);
        set_wb(3, 0, 64'hDEAD, 1'b1);
        step(); clr_wb(); #1;
        chk("wb0_valid", 64'(commit_valid_o), 64'h3);
        chk("wb0_result0", commit_result_o[0], 64'hB);
        chk("wb0_result1", commit_result_o[1], 64'hA);

        // full + retire + issue: issue rejected this cycle, tail wraps to 0 next
        issue_valid_i = 1'b1;
        issue_pc_i    = VLEN'(64'h200);
        issue_rd_i    = 5'd9;
        #1;
        chk("full_ack_ready", 64'(issue_ready_o), 64'd0);
        do_commit(1);
        issue_valid_i = 1'b0;
        do_issue(VLEN'(64'h200), 5'd9);

        // out-of-order ack ignored
        set_wb(0, 2, 64'hC, 1'b0);
        step(); clr_wb(); #1;
        chk("ooo_valid_pre", 64'(commit_valid_o), 64'h3);
        commit_ack_i = 2'b10;
        step();
        commit_ack_i = '0;
        #1;
        chk("ooo_head", 64'(commit_tid_o[0]), 64'd1);
        chk("ooo_valid_post", 64'(commit_valid_o), 64'h3);
        do_commit(2);
        #1;
        chk("ack11_head", 64'(commit_tid_o[0]), 64'd3);
        chk("ack11_valid", 64'(commit_valid_o), 64'd0);
        do_issue(VLEN'(64'h204), 5'd10);
        do_issue(VLEN'(64'h208), 5'd11);
        #1;
        chk("count6_refill_ready", 64'(issue_ready_o), 64'd0);

        // three ports in one cycle, one with exception
        set_wb(0, 3, 64'h33, 1'b1);
        set_wb(1, 5, 64'h55, 1'b0);
        set_wb(2, 4, 64'h44, 1'b0);
        step(); clr_wb();
        do_commit(2);
        do_commit(1);

        // flush with 5 allocated, plus same-cycle wb and issue
        flush_i       = 1'b1;
        issue_valid_i = 1'b1;
        issue_pc_i    = VLEN'(64'h300);
        set_wb(0, 6, 64'h66, 1'b0);
        step();
        flush_i = 1'b0; issue_valid_i = 1'b0; clr_wb(); #1;
        chk("flush_valid", 64'(commit_valid_o), 64'd0);
        chk("flush_ready", 64'(issue_ready_o), 64'd1);
        chk("flush_tid", 64'(issue_tid_o), 64'd0);
        chk("flush_head", 64'(commit_tid_o[0]), 64'd0);
        exp_q.delete();
        m_tail = 0;

        // writeback-to-commit latency
        do_issue(VLEN'(64'h400), 5'd7);
        do_issue(VLEN'(64'h404), 5'd8);
        set_wb(0, 0, 64'h55, 1'b0);
`ifdef COMMIT_ROB_WB_BYPASS_EN
        do_commit(1);
        clr_wb();
`else
        #1;
        chk("nobyp_valid_same_cycle", 64'(commit_valid_o[0]), 64'd0);
        step(); clr_wb();
        do_commit(1);
`endif
        #1;
        chk("lat_head", 64'(commit_tid_o[0]), 64'd1);
        chk("lat_valid", 64'(commit_valid_o), 64'd0);
        set_wb(0, 1, 64'h77, 1'b0);
        step(); clr_wb();
        do_commit(1);
        #1;
        chk("drain_valid", 64'(commit_valid_o), 64'd0);
        chk("drain_ready", 64'(issue_ready_o), 64'd1);
        chk("drain_tid", 64'(issue_tid_o), 64'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
